// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Instruction-fetch stage of the MIPS pipeline. Owns the program counter,
// drives the synchronous program-memory read port and presents the fetched
// instruction (plus its opcode and address) to the stall control block.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high clear of all state
//   stall        freezes the PC and suppresses new memory reads
//   stall_pm     registered stall; holds the currently presented instruction
//   jump_en      redirect request from decode
//   jump_addr    redirect target
//   pm_addr      program-memory read address (the PC)
//   pm_rd_en     program-memory read enable
//   pm_rdata     read data, valid one cycle after pm_rd_en
//   instr        instruction presented downstream (0 = NOP when none)
//   op           top six bits of instr
//   instr_pc     address of the presented instruction
//   instr_valid  instr is a real fetched instruction
//   halted       an HLT instruction has retired; fetch is parked until reset
module pc_fetch_unit #(
  parameter int PC_W     = 16,
  parameter int INSTR_W  = 32,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               stall_pm,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_addr,
  output logic [PC_W-1:0]    pm_addr,
  output logic               pm_rd_en,
  input  logic [INSTR_W-1:0] pm_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               halted
);

  localparam logic [1:0] ST_PRIME = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [5:0]      OP_HLT     = 6'b010001;
  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               rd_q, rd_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic [INSTR_W-1:0] instr_hold_q, instr_hold_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic               valid_hold_q, valid_hold_d;
  logic               halted_q, halted_d;

  logic               rd_en_s;
  logic [INSTR_W-1:0] instr_s;
  logic [PC_W-1:0]    instr_pc_s;
  logic               instr_valid_s;
  logic               hlt_s;

  // Read enable: PRIME always issues the first fetch, RUN fetches unless stalled.
  always_comb begin
    rd_en_s = 1'b0;
    case (state_q)
      ST_PRIME: rd_en_s = 1'b1;
      ST_RUN:   rd_en_s = ~stall;
      default:  rd_en_s = 1'b0;
    endcase
  end

  // Presentation mux. Once parked, only a NOP is shown; the HLT itself was
  // presented in the detection cycle while still in RUN.
  always_comb begin
    instr_s       = '0;
    instr_pc_s    = '0;
    instr_valid_s = 1'b0;
    if (state_q == ST_HALT) begin
      instr_s       = '0;
      instr_pc_s    = '0;
      instr_valid_s = 1'b0;
    end else if (stall_pm) begin
      instr_s       = instr_hold_q;
      instr_pc_s    = hold_pc_q;
      instr_valid_s = valid_hold_q;
    end else if (rd_q) begin
      instr_s       = pm_rdata;
      instr_pc_s    = req_pc_q;
      instr_valid_s = 1'b1;
    end else begin
      instr_s       = '0;
      instr_pc_s    = req_pc_q;
      instr_valid_s = 1'b0;
    end
  end

  // HLT is only recognised on a freshly presented, real instruction.
  always_comb begin
    hlt_s = (state_q == ST_RUN) && instr_valid_s && !stall_pm &&
            (instr_s[INSTR_W-1:INSTR_W-6] == OP_HLT);
  end

  // Next-state / next-PC. HLT outranks a jump; a jump outranks stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    case (state_q)
      ST_PRIME: begin
        state_d = ST_RUN;
        pc_d    = RESET_PC_V + PC_ONE;
      end
      ST_RUN: begin
        if (hlt_s) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (jump_en) begin
          pc_d = jump_addr;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end
      ST_HALT: begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_PRIME;
        pc_d    = RESET_PC_V;
      end
    endcase
  end

  // Read pipeline and hold registers for the registered-stall path.
  always_comb begin
    rd_d     = rd_en_s;
    req_pc_d = rd_en_s ? pc_q : req_pc_q;
    if (!stall_pm) begin
      instr_hold_d = instr_s;
      hold_pc_d    = instr_pc_s;
      valid_hold_d = instr_valid_s;
    end else begin
      instr_hold_d = instr_hold_q;
      hold_pc_d    = hold_pc_q;
      valid_hold_d = valid_hold_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_PRIME;
      pc_q         <= RESET_PC_V;
      rd_q         <= 1'b0;
      req_pc_q     <= '0;
      instr_hold_q <= '0;
      hold_pc_q    <= '0;
      valid_hold_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      req_pc_q     <= req_pc_d;
      instr_hold_q <= instr_hold_d;
      hold_pc_q    <= hold_pc_d;
      valid_hold_q <= valid_hold_d;
      halted_q     <= halted_d;
    end
  end

  assign pm_addr     = pc_q;
  assign pm_rd_en    = rd_en_s;
  assign instr       = instr_s;
  assign op          = instr_s[INSTR_W-1:INSTR_W-6];
  assign instr_pc    = instr_pc_s;
  assign instr_valid = instr_valid_s;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit (PC_W=8). A stimulus process drives inputs on
// the falling edge and pushes the expected outputs, computed by a behavioural
// fetch model, into a queue; a monitor process pops and compares.
module tb_pc_fetch_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int M_PRIME = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall, stall_pm, jump_en;
  logic [PC_W-1:0]    jump_addr;
  logic [PC_W-1:0]    pm_addr;
  logic               pm_rd_en;
  logic [INSTR_W-1:0] pm_rdata;
  logic [INSTR_W-1:0] instr;
  logic [5:0]         op;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               halted;

  pc_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm),
    .jump_en(jump_en), .jump_addr(jump_addr), .pm_addr(pm_addr),
    .pm_rd_en(pm_rd_en), .pm_rdata(pm_rdata), .instr(instr), .op(op),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous program memory.
  logic [INSTR_W-1:0] mem [0:255];
  initial pm_rdata = '0;
  always @(posedge clk) if (pm_rd_en) pm_rdata <= mem[pm_addr];

  typedef struct {
    logic [PC_W-1:0]    addr;
    logic               rd_en;
    logic               halted;
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    ipc;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model state.
  int              m_mode;
  logic [PC_W-1:0] m_pc;
  logic            m_prev_rd;
  logic [PC_W-1:0] m_prev_addr;
  logic            h_valid;
  logic [31:0]     h_instr;
  logic [PC_W-1:0] h_pc;
  logic            last_stall;

  task automatic model_reset();
    m_mode = M_PRIME; m_pc = '0; m_prev_rd = 1'b0; m_prev_addr = '0;
    h_valid = 1'b0; h_instr = '0; h_pc = '0; last_stall = 1'b0;
  endtask

  // One clock of stimulus: drive, predict, advance model, wait for next negedge.
  task automatic step(input logic st, input logic spm, input logic je, input logic [PC_W-1:0] ja);
    exp_t e;
    logic hlt;
    logic [5:0] opc;
    stall = st; stall_pm = spm; jump_en = je; jump_addr = ja;
    e.addr   = m_pc;
    e.rd_en  = (m_mode == M_PRIME) ? 1'b1 : (m_mode == M_RUN) ? !st : 1'b0;
    e.halted = (m_mode == M_HALT);
    if (m_mode == M_HALT) begin
      e.valid = 1'b0; e.instr = '0; e.ipc = '0;
    end else if (spm) begin
      e.valid = h_valid; e.instr = h_instr; e.ipc = h_pc;
    end else if (m_prev_rd) begin
      e.valid = 1'b1; e.instr = mem[m_prev_addr]; e.ipc = m_prev_addr;
    end else begin
      e.valid = 1'b0; e.instr = '0; e.ipc = m_prev_addr;
    end
    exp_q.push_back(e);
    opc = e.instr[31:26];
    hlt = (m_mode == M_RUN) && e.valid && !spm && (opc == 6'b010001);
    if (m_mode != M_HALT && !spm) begin
      h_valid = e.valid; h_instr = e.instr; h_pc = e.ipc;
    end
    if (e.rd_en) m_prev_addr = m_pc;
    m_prev_rd = e.rd_en;
    if (m_mode == M_PRIME) begin
      m_mode = M_RUN; m_pc = 8'd1;
    end else if (m_mode == M_RUN) begin
      if (hlt) m_mode = M_HALT;
      else if (je) m_pc = ja;
      else if (!st) m_pc = m_pc + 8'd1;
    end
    last_stall = st;
    @(negedge clk);
  endtask

  // Random step: stall_pm normally follows the previous stall.
  task automatic rand_step(input int jump_pct);
    logic st, spm, je;
    logic [PC_W-1:0] ja;
    st  = ($urandom_range(0, 3) == 0);
    spm = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : last_stall;
    je  = ($urandom_range(0, 99) < jump_pct);
    ja  = PC_W'($urandom_range(0, 255));
    step(st, spm, je, ja);
  endtask

  // Assert reset between clock edges, check the async clear, release on a negedge.
  task automatic do_reset();
    #2;
    reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; jump_en = 1'b0; jump_addr = '0;
    #1;
    chk("rst_pm_addr", 32'(pm_addr), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: compare DUT outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pm_addr", 32'(pm_addr), 32'(e.addr));
        chk("pm_rd_en", 32'(pm_rd_en), 32'(e.rd_en));
        chk("halted", 32'(halted), 32'(e.halted));
        chk("instr_valid", 32'(instr_valid), 32'(e.valid));
        chk("instr", instr, e.instr);
        chk("op", 32'(op), 32'(e.instr[31:26]));
        if (e.valid) chk("instr_pc", 32'(instr_pc), 32'(e.ipc));
      end
    end
  end

  initial begin
    logic [31:0] w;
    logic [5:0]  wop;
    int          hp;
    reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; jump_en = 1'b0; jump_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    model_reset();
    do_reset();

    // Reset sequence and 2-cycle stall at pc=5 with stall_pm following.
    for (int i = 0; i < 5; i++) step(1'b0, last_stall, 1'b0, 8'h00);
    step(1'b1, last_stall, 1'b0, 8'h00);
    step(1'b1, last_stall, 1'b0, 8'h00);
    step(1'b0, last_stall, 1'b0, 8'h00);
    step(1'b0, last_stall, 1'b0, 8'h00);
    // Jump with stall at pc=7.
    step(1'b1, last_stall, 1'b1, 8'h40);
    for (int i = 0; i < 3; i++) step(1'b0, last_stall, 1'b0, 8'h00);
    // Wrap from 0xFE.
    step(1'b0, last_stall, 1'b1, 8'hFE);
    for (int i = 0; i < 5; i++) step(1'b0, last_stall, 1'b0, 8'h00);
    // Random run.
    for (int i = 0; i < 400; i++) rand_step(10);
    // Async reset mid-run at pc=0x20.
    step(1'b0, last_stall, 1'b1, 8'h1E);
    step(1'b0, last_stall, 1'b0, 8'h00);
    step(1'b0, last_stall, 1'b0, 8'h00);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, last_stall, 1'b0, 8'h00);

    // HLT at address 3, with a same-cycle jump on the HLT presentation.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      wop = w[31:26];
      if (wop == 6'b010001) w[31:26] = 6'b000000;
      mem[i] = w;
    end
    w = mem[3];
    w[31:26] = 6'b010001;
    mem[3] = w;
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, last_stall, 1'b0, 8'h00);
    step(1'b0, last_stall, 1'b1, 8'h80);
    for (int i = 0; i < 20; i++) rand_step(30);

    // Randomly placed HLT under random traffic.
    reset = 1'b1;
    hp = $urandom_range(8, 255);
    w = mem[hp];
    w[31:26] = 6'b010001;
    mem[hp] = w;
    do_reset();
    for (int i = 0; i < 400; i++) rand_step(15);

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
